pea_fifo: RTL and testbench
===========================

# pea_fifo

Synchronous single-clock token FIFO that carries command, data, result and status streams between the Polynomial Evaluation Accelerator (PEA) actors. Besides storing tokens, it publishes its current token count and remaining capacity every cycle. Enable logic uses those counts to decide whether an actor may fire: input FIFOs are checked for enough tokens, output FIFOs for enough free space. One instance is placed per dataflow edge, with `word_size` set to that edge's token width: 16 for command and data, 32 for result.

## Interface
Parameters:
- `word_size`, default 16: token width in bits.
- `buffer_size`, default 1024: capacity in tokens. Any value ≥ 1 is allowed; a power of two is not required.
- `CW`, a localparam equal to log2(buffer_size)+1: width of the count outputs.
  - log2 is the ceiling log2, with log2(1) defined as 1.
  - The extra bit lets a full FIFO (count = buffer_size) be represented.

Ports:
- `clk`, input, 1 bit: the single clock; all logic is on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `wr_en`, input, 1 bit: push `data_in` on this edge.
- `data_in`, input, `word_size` bits: token to write.
- `rd_en`, input, 1 bit: pop the head token on this edge.
- `data_out`, output, `word_size` bits, registered: last popped token.
- `population`, output, CW bits, registered: tokens currently stored.
- `free_space`, output, CW bits, registered: equal to buffer_size − population.
- `full`, output, 1 bit, registered: high when population == buffer_size.
- `empty`, output, 1 bit, registered: high when population == 0.
- `wr_err`, output, 1 bit, registered: one-cycle pulse when a write is rejected.
- `rd_err`, output, 1 bit, registered: one-cycle pulse when a read is rejected.

## Operation
- Storage is a `buffer_size` × `word_size` array, addressed by `wr_ptr` and `rd_ptr`, each in the range 0..buffer_size−1.
- Pointer wrap: when a pointer is at buffer_size−1 and advances, it returns to 0. This is an explicit compare, not modulo-2^n, so non-power-of-two sizes work.
- Accepted write (`wr_en` and not `full`): mem[wr_ptr] ← data_in, then wr_ptr advances.
- Accepted read (`rd_en` and not `empty`): data_out ← mem[rd_ptr], then rd_ptr advances.
- Rejected read: `data_out` holds its previous value and `rd_err` pulses.
- Rejected write: storage is unchanged and `wr_err` pulses.
- Simultaneous `wr_en` and `rd_en`:
  - Not empty and not full: both are accepted and population is unchanged.
  - Full: both are accepted (the read frees the slot the write fills); population stays at buffer_size.
  - Empty: only the write is accepted. There is no bypass, so `data_out` is not updated and `rd_err` pulses. The written token becomes readable next cycle.
- Population update, using the accepted operations only: +1 for a write alone, −1 for a read alone, 0 for both or neither.
- `free_space`, `full` and `empty` are registered alongside population, so all four are always consistent in the same cycle.
- Memory contents are not cleared by reset; they are unreachable until rewritten.

## Timing
- Reset values, applied on a `clk` edge with `rst` high:
  - wr_ptr = rd_ptr = 0
  - population = 0, free_space = buffer_size
  - empty = 1, full = 0
  - data_out = 0
  - wr_err = rd_err = 0
- `rst` has priority over `wr_en` and `rd_en` in the same cycle. Both are ignored, even if the FIFO was mid-stream, and all pending contents are discarded.
- Write latency: a token written at edge k is visible to a read at edge k+1. The counts reflect it after edge k.
- Read latency: `data_out` is valid in the cycle after the accepting edge and holds until the next accepted read or reset.
- Count outputs change only on edges. They are never combinational from `wr_en`/`rd_en`, so enable logic sees stable values for the whole cycle.
- Error pulses last exactly one cycle per rejected request. Consecutive rejected requests produce a continuously high error output.
- Sustained throughput is one write and one read per cycle.

## Test plan
- Reset: with buffer_size=4, assert `rst` for 2 cycles → population=0, free_space=4, empty=1, full=0, data_out=0.
- Fill and overflow:
  - Write 0x0001..0x0004 on consecutive cycles → population steps 1,2,3,4; full=1 after the 4th write.
  - A 5th write of 0x0005 → wr_err=1 for one cycle and population stays 4.
- Drain and underflow:
  - 4 reads → data_out = 0x0001, 0x0002, 0x0003, 0x0004 (each one cycle after its read); empty=1 after the last.
  - A 5th read → rd_err=1 and data_out stays 0x0004.
- Wrap and simultaneous access:
  - Write 3, read 2, then 6 cycles of simultaneous read+write → population stays 1 and data_out follows write order across the pointer wrap.
  - Simultaneous read+write when full → population stays 4 with no error.
- Empty corner: simultaneous read+write with population=0 → population=1, rd_err=1, data_out unchanged.
- Reset mid-stream: assert `rst` with population=3 while `wr_en` and `rd_en` are high → next cycle population=0 and free_space=4.
  - Then write 0xBEEF and read → data_out=0xBEEF, with no stale token.

Source files
------------

// File: rtl/pea_fifo.sv
// Single-clock token FIFO for PEA dataflow edges; publishes registered token
// count and free space every cycle so actor enable logic sees stable values.
module pea_fifo #(
  parameter int unsigned word_size   = 16,
  parameter int unsigned buffer_size = 1024,
  localparam int unsigned AW = (buffer_size > 1) ? $clog2(buffer_size) : 1,
  localparam int unsigned CW = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [word_size-1:0] data_in,
  input  logic                 rd_en,
  output logic [word_size-1:0] data_out,
  output logic [CW-1:0]        population,
  output logic [CW-1:0]        free_space,
  output logic                 full,
  output logic                 empty,
  output logic                 wr_err,
  output logic                 rd_err
);

  logic [word_size-1:0] mem_q [buffer_size];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        pop_q, pop_d;
  logic [CW-1:0]        free_q, free_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic [word_size-1:0] dout_q, dout_d;
  logic                 wr_err_q, wr_err_d;
  logic                 rd_err_q, rd_err_d;
  logic                 rd_ok_c, wr_ok_c;

  // A read on a full FIFO frees the slot, so a simultaneous write is accepted too.
  always_comb begin
    rd_ok_c  = rd_en && !empty_q;
    wr_ok_c  = wr_en && (!full_q || rd_ok_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_d    = pop_q;
    dout_d   = dout_q;
    wr_err_d = wr_en && !wr_ok_c;
    rd_err_d = rd_en && !rd_ok_c;

    if (wr_ok_c) begin
      wr_ptr_d = (wr_ptr_q == AW'(buffer_size - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_ok_c) begin
      rd_ptr_d = (rd_ptr_q == AW'(buffer_size - 1)) ? '0 : rd_ptr_q + AW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    if (wr_ok_c && !rd_ok_c) begin
      pop_d = pop_q + CW'(1);
    end else if (rd_ok_c && !wr_ok_c) begin
      pop_d = pop_q - CW'(1);
    end

    free_d  = CW'(buffer_size) - pop_d;
    full_d  = (pop_d == CW'(buffer_size));
    empty_d = (pop_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pop_q    <= '0;
      free_q   <= CW'(buffer_size);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pop_q    <= pop_d;
      free_q   <= free_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is not cleared by reset; stale words are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = dout_q;
  assign population = pop_q;
  assign free_space = free_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign wr_err     = wr_err_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_pea_fifo.sv
// Scoreboard bench for pea_fifo (buffer_size=4): a queue-based token model
// produces the expected post-edge outputs, a monitor compares them.
module tb_pea_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WS    = 16;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [WS-1:0] data_in;
  logic [WS-1:0] data_out;
  logic [CW-1:0] population, free_space;
  logic          full, empty, wr_err, rd_err;

  pea_fifo #(.word_size(WS), .buffer_size(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .population(population), .free_space(free_space),
    .full(full), .empty(empty), .wr_err(wr_err), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] dout;
    int            pop;
    logic          werr;
    logic          rerr;
  } exp_t;

  exp_t          sb[$];
  logic [WS-1:0] mq[$];
  logic [WS-1:0] m_dout;
  int            errors = 0;
  int            checks = 0;
  bit            done   = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the FIFO must show after the edge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [WS-1:0] d);
    exp_t e;
    bit   rok, wok;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    if (r) begin
      mq.delete();
      m_dout = '0;
      e.werr = 1'b0;
      e.rerr = 1'b0;
    end else begin
      rok = rd && (mq.size() > 0);
      wok = w && ((mq.size() < DEPTH) || rok);
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d);
      e.werr = w && !wok;
      e.rerr = rd && !rok;
    end
    e.dout = m_dout;
    e.pop  = mq.size();
    sb.push_back(e);
  endtask

  // Monitor: every edge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data_out",   int'(data_out),   int'(e.dout));
        check("population", int'(population), e.pop);
        check("free_space", int'(free_space), int'(DEPTH) - e.pop);
        check("full",       int'(full),       int'(e.pop == int'(DEPTH)));
        check("empty",      int'(empty),      int'(e.pop == 0));
        check("wr_err",     int'(wr_err),     int'(e.werr));
        check("rd_err",     int'(rd_err),     int'(e.rerr));
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; m_dout = '0;
    cyc(1, 0, 0, 16'h0);
    cyc(1, 0, 0, 16'h0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, WS'(i));      // fill + overflow
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'h0);        // drain + underflow
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, WS'(16'h10 + i));
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 16'h0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, WS'(16'h20 + i)); // wrap, pop=1
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, WS'(16'h30 + i)); // to full
    cyc(0, 1, 1, 16'h0040);                                 // full r+w
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 16'h0);
    cyc(0, 1, 1, 16'h0050);                                 // empty corner
    cyc(0, 1, 0, 16'h0051);
    cyc(0, 1, 0, 16'h0052);                                 // pop=3
    cyc(1, 1, 1, 16'h0053);                                 // reset mid-stream
    cyc(0, 1, 0, 16'hBEEF);
    cyc(0, 0, 1, 16'h0);
    cyc(0, 0, 1, 16'h0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 50), WS'($urandom));
    end
    cyc(0, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
